// File: rtl/tremolo_sincos_cordic_if.sv
// Angle request / sine-cosine result bundle between the tremolo LFO and its CORDIC engine.
interface tremolo_sincos_cordic_if;
    logic        [31:0] angle_in;
    logic               angle_valid;
    logic signed [31:0] sin_out;
    logic signed [31:0] cos_out;
    logic               sin_valid;
    logic               busy;

    modport master (
        output angle_in,
        output angle_valid,
        input  sin_out,
        input  cos_out,
        input  sin_valid,
        input  busy
    );

    modport slave (
        input  angle_in,
        input  angle_valid,
        output sin_out,
        output cos_out,
        output sin_valid,
        output busy
    );
endinterface

// File: rtl/tremolo_sincos_cordic.sv
// Iterative CORDIC sine/cosine engine for the tremolo LFO: folds an angle in [0, 8) rad
// into the first quadrant, rotates one micro-step per clock, then restores the signs.
module tremolo_sincos_cordic #(
    parameter int ITERATIONS = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    tremolo_sincos_cordic_if.slave cordic_if
);

    localparam logic        [31:0] TWO_PI   = 32'hC90F_DAA2;
    localparam logic        [31:0] PI_2     = 32'h3243_F6A9;
    localparam logic        [31:0] PI       = 32'h6487_ED51;
    localparam logic        [31:0] PI_3_2   = 32'h96CB_E3FA;
    localparam logic signed [33:0] K_GAIN   = 34'sh0_26DD_3B6A;
    localparam logic signed [33:0] POS_ONE  = 34'sh0_4000_0000;
    localparam logic signed [33:0] NEG_ONE  = -POS_ONE;
    localparam logic        [4:0]  LAST_ITER = 5'(ITERATIONS - 1);

    typedef enum logic [1:0] {
        IDLE,
        REDUCE,
        ROTATE,
        FINISH
    } state_t;

    state_t             state_q;
    logic               edgeReg_q;
    logic        [31:0] angleLatch_q;
    logic        [1:0]  quad_q;
    logic signed [33:0] xAcc_q, yAcc_q, zAcc_q;
    logic        [4:0]  iter_q;
    logic signed [31:0] sinOut_q, cosOut_q;
    logic               sinValid_q, busy_q;

    logic               request;
    logic        [31:0] angleWrap;
    logic        [1:0]  quad_d;
    logic        [31:0] angleFold;
    logic signed [33:0] xAcc_d, yAcc_d, zAcc_d;
    logic signed [33:0] sinSel, cosSel;

    // round(atan(2^-i) * 2^29); from i = 10 on this equals 2^(29-i)
    function automatic logic signed [33:0] atanRom(input logic [4:0] idx);
        logic signed [33:0] val;
        case (idx)
            5'd0:    val = 34'sd421657428;
            5'd1:    val = 34'sd248918915;
            5'd2:    val = 34'sd131521918;
            5'd3:    val = 34'sd66762579;
            5'd4:    val = 34'sd33510843;
            5'd5:    val = 34'sd16771758;
            5'd6:    val = 34'sd8387925;
            5'd7:    val = 34'sd4194219;
            5'd8:    val = 34'sd2097141;
            5'd9:    val = 34'sd1048575;
            default: val = 34'sd1 <<< (5'd29 - idx);
        endcase
        return val;
    endfunction

    function automatic logic signed [31:0] saturate(input logic signed [33:0] v);
        logic signed [31:0] res;
        if (v > POS_ONE) begin
            res = 32'sh4000_0000;
        end else if (v < NEG_ONE) begin
            res = 32'shC000_0000;
        end else begin
            res = v[31:0];
        end
        return res;
    endfunction

    assign request = cordic_if.angle_valid && !edgeReg_q;

    always_comb begin
        angleWrap = (angleLatch_q >= TWO_PI) ? (angleLatch_q - TWO_PI) : angleLatch_q;
        if (angleWrap < PI_2) begin
            quad_d    = 2'd0;
            angleFold = angleWrap;
        end else if (angleWrap < PI) begin
            quad_d    = 2'd1;
            angleFold = PI - angleWrap;
        end else if (angleWrap < PI_3_2) begin
            quad_d    = 2'd2;
            angleFold = angleWrap - PI;
        end else begin
            quad_d    = 2'd3;
            angleFold = TWO_PI - angleWrap;
        end
    end

    always_comb begin
        if (!zAcc_q[33]) begin
            xAcc_d = xAcc_q - (yAcc_q >>> iter_q);
            yAcc_d = yAcc_q + (xAcc_q >>> iter_q);
            zAcc_d = zAcc_q - atanRom(iter_q);
        end else begin
            xAcc_d = xAcc_q + (yAcc_q >>> iter_q);
            yAcc_d = yAcc_q - (xAcc_q >>> iter_q);
            zAcc_d = zAcc_q + atanRom(iter_q);
        end
        sinSel = quad_q[1] ? -yAcc_q : yAcc_q;
        cosSel = (quad_q == 2'd1 || quad_q == 2'd2) ? -xAcc_q : xAcc_q;
    end

    // busy drops in the IDLE cycle after FINISH so it still covers the sin_valid cycle,
    // which also makes a request landing on that cycle a dropped one
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            edgeReg_q    <= 1'b0;
            angleLatch_q <= '0;
            quad_q       <= '0;
            xAcc_q       <= '0;
            yAcc_q       <= '0;
            zAcc_q       <= '0;
            iter_q       <= '0;
            sinOut_q     <= '0;
            cosOut_q     <= '0;
            sinValid_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            edgeReg_q <= cordic_if.angle_valid;
            case (state_q)
                IDLE: begin
                    sinValid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    if (request && !busy_q) begin
                        angleLatch_q <= cordic_if.angle_in;
                        busy_q       <= 1'b1;
                        state_q      <= REDUCE;
                    end
                end
                REDUCE: begin
                    quad_q  <= quad_d;
                    zAcc_q  <= {2'b00, angleFold};
                    xAcc_q  <= K_GAIN;
                    yAcc_q  <= '0;
                    iter_q  <= '0;
                    state_q <= ROTATE;
                end
                ROTATE: begin
                    xAcc_q <= xAcc_d;
                    yAcc_q <= yAcc_d;
                    zAcc_q <= zAcc_d;
                    iter_q <= iter_q + 5'd1;
                    if (iter_q == LAST_ITER) begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    sinOut_q   <= saturate(sinSel);
                    cosOut_q   <= saturate(cosSel);
                    sinValid_q <= 1'b1;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cordic_if.sin_out   = sinOut_q;
    assign cordic_if.cos_out   = cosOut_q;
    assign cordic_if.sin_valid = sinValid_q;
    assign cordic_if.busy      = busy_q;

endmodule

// File: tb/tb_tremolo_sincos_cordic.sv
// Directed-vector bench for the tremolo CORDIC: hand-computed table, real-number sweep,
// and hand-written sequences for held requests, busy drops and mid-job reset.
module tb_tremolo_sincos_cordic;

   localparam longint TOL = 256;
   localparam logic [31:0] PI_2   = 32'h3243_F6A9;
   localparam logic [31:0] PI     = 32'h6487_ED51;
   localparam logic [31:0] PI_3_2 = 32'h96CB_E3FA;
   localparam logic [31:0] TWO_PI = 32'hC90F_DAA2;

   typedef struct {
      string       name;
      logic [31:0] angle;
      longint      expSin;
      longint      expCos;
   } vec_t;

   logic clk;
   logic rst;
   int   nCompared;
   int   nMismatched;

   tremolo_sincos_cordic_if cordicBus ();

   tremolo_sincos_cordic #(.ITERATIONS(24)) dut (
      .clk       (clk),
      .rst       (rst),
      .cordic_if (cordicBus.slave)
   );

   // free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // one comparison with tolerance; every failure prints a single FAIL line
   task automatic checkOutput(input string name, input longint actual, input longint expected, input longint tol);
      longint diff;
      nCompared++;
      diff = actual - expected;
      if (diff < 0) diff = -diff;
      if (diff > tol) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0d, want %0d (tol %0d)", name, actual, expected, tol);
      end
   endtask

   // waits (bounded) for the sin_valid pulse, sampling 1 ns after each rising edge
   task automatic waitValid(output int cycles, output bit timedOut);
      cycles = 0;
      while (!cordicBus.sin_valid && cycles < 60) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      timedOut = !cordicBus.sin_valid;
   endtask

   // issues a single-cycle request and returns inside the sin_valid cycle
   task automatic applyStimulus(input logic [31:0] angle, output int latency);
      bit timedOut;
      @(posedge clk);
      #1;
      cordicBus.angle_in    = angle;
      cordicBus.angle_valid = 1'b1;
      @(posedge clk);
      #1;
      cordicBus.angle_valid = 1'b0;
      waitValid(latency, timedOut);
      checkOutput("sin_valid timeout", longint'(timedOut), 0, 0);
   endtask

   // real-number reference, clipped to the +-1.0 saturation range
   function automatic longint modelTrig(input logic [31:0] angle, input bit wantCos);
      real ang;
      real v;
      ang = real'(longint'(angle)) / 536870912.0;
      v   = (wantCos ? $cos(ang) : $sin(ang)) * 1073741824.0;
      if (v > 1073741824.0) v = 1073741824.0;
      if (v < -1073741824.0) v = -1073741824.0;
      return longint'($rtoi(v >= 0.0 ? v + 0.5 : v - 0.5));
   endfunction

   function automatic longint sinNow();
      return longint'(cordicBus.sin_out);
   endfunction

   function automatic longint cosNow();
      return longint'(cordicBus.cos_out);
   endfunction

   // main sequence
   initial begin
      vec_t        vecs[5];
      logic [31:0] edgeAngles[13];
      int          lat;
      int          pulses;
      bit          timedOut;

      nCompared   = 0;
      nMismatched = 0;

      vecs[0] = '{"zero",    32'h0000_0000,          0,  1073741824};
      vecs[1] = '{"pi/2",    PI_2,           1073741824,          0};
      vecs[2] = '{"pi",      PI,                      0, -1073741824};
      vecs[3] = '{"4.0rad",  32'h8000_0000,  -812610492, -701844494};
      vecs[4] = '{"6.5rad",  32'hD000_0000,   230983328, 1048602978};

      edgeAngles = '{PI_2 - 32'd1, PI_2, PI_2 + 32'd1, PI - 32'd1, PI, PI + 32'd1,
                     PI_3_2 - 32'd1, PI_3_2, PI_3_2 + 32'd1,
                     TWO_PI - 32'd1, TWO_PI, TWO_PI + 32'd1, 32'hFFFF_FFFF};

      cordicBus.angle_in    = '0;
      cordicBus.angle_valid = 1'b0;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset sin_out",   sinNow(), 0, 0);
      checkOutput("reset cos_out",   cosNow(), 0, 0);
      checkOutput("reset sin_valid", longint'(cordicBus.sin_valid), 0, 0);
      checkOutput("reset busy",      longint'(cordicBus.busy), 0, 0);
      rst = 1'b1;
      repeat (2) @(posedge clk);

      $display("[TB] directed table");
      for (int v = 0; v < 5; v++) begin
         applyStimulus(vecs[v].angle, lat);
         checkOutput({vecs[v].name, " latency"}, longint'(lat), 26, 0);
         checkOutput({vecs[v].name, " busy on valid"}, longint'(cordicBus.busy), 1, 0);
         checkOutput({vecs[v].name, " sin"}, sinNow(), vecs[v].expSin, TOL);
         checkOutput({vecs[v].name, " cos"}, cosNow(), vecs[v].expCos, TOL);
         @(posedge clk);
         #1;
         checkOutput({vecs[v].name, " valid/busy after pulse"},
                     longint'({cordicBus.sin_valid, cordicBus.busy}), 0, 0);
      end

      $display("[TB] quadrant boundary points");
      for (int e = 0; e < 13; e++) begin
         applyStimulus(edgeAngles[e], lat);
         checkOutput($sformatf("edge %h sin", edgeAngles[e]), sinNow(), modelTrig(edgeAngles[e], 1'b0), TOL);
         checkOutput($sformatf("edge %h cos", edgeAngles[e]), cosNow(), modelTrig(edgeAngles[e], 1'b1), TOL);
      end

      $display("[TB] coarse angle sweep");
      for (longint a = 0; a <= 64'h0000_0000_FFFF_FFF8; a += 64'h0000_0000_0112_8400) begin
         applyStimulus(a[31:0], lat);
         checkOutput($sformatf("sweep %h sin", a[31:0]), sinNow(), modelTrig(a[31:0], 1'b0), TOL);
         checkOutput($sformatf("sweep %h cos", a[31:0]), cosNow(), modelTrig(a[31:0], 1'b1), TOL);
      end

      $display("[TB] held request");
      @(posedge clk);
      #1;
      cordicBus.angle_in    = 32'hD000_0000;
      cordicBus.angle_valid = 1'b1;
      pulses = 0;
      for (int c = 0; c < 100; c++) begin
         @(posedge clk);
         #1;
         if (cordicBus.sin_valid) pulses++;
      end
      cordicBus.angle_valid = 1'b0;
      checkOutput("held request pulses", longint'(pulses), 1, 0);
      checkOutput("held request sin", sinNow(), 230983328, TOL);

      $display("[TB] request while busy");
      @(posedge clk);
      #1;
      cordicBus.angle_in    = 32'h8000_0000;
      cordicBus.angle_valid = 1'b1;
      @(posedge clk);
      #1;
      cordicBus.angle_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      cordicBus.angle_in    = 32'h0000_0000;
      cordicBus.angle_valid = 1'b1;
      @(posedge clk);
      #1;
      cordicBus.angle_valid = 1'b0;
      cordicBus.angle_in    = PI_2;
      waitValid(lat, timedOut);
      checkOutput("busy drop timeout", longint'(timedOut), 0, 0);
      checkOutput("busy drop sin", sinNow(), -812610492, TOL);
      checkOutput("busy drop cos", cosNow(), -701844494, TOL);
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (cordicBus.sin_valid) pulses++;
      end
      checkOutput("busy drop extra pulses", longint'(pulses), 0, 0);

      $display("[TB] reset during rotation");
      @(posedge clk);
      #1;
      cordicBus.angle_in    = PI_2;
      cordicBus.angle_valid = 1'b1;
      @(posedge clk);
      #1;
      cordicBus.angle_valid = 1'b0;
      repeat (11) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      checkOutput("mid-job reset sin_out",   sinNow(), 0, 0);
      checkOutput("mid-job reset cos_out",   cosNow(), 0, 0);
      checkOutput("mid-job reset sin_valid", longint'(cordicBus.sin_valid), 0, 0);
      checkOutput("mid-job reset busy",      longint'(cordicBus.busy), 0, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (cordicBus.sin_valid) pulses++;
      end
      checkOutput("post-reset stray pulses", longint'(pulses), 0, 0);
      applyStimulus(PI, lat);
      checkOutput("post-reset latency", longint'(lat), 26, 0);
      checkOutput("post-reset sin", sinNow(), 0, TOL);
      checkOutput("post-reset cos", cosNow(), -1073741824, TOL);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
